// File: rtl/key_scan_arbiter.sv
// ============================================================================
// Module  : key_scan_arbiter
// Brief   : Round-robin key scanner sharing one debounce FSM across NUM_KEYS
//           inputs; emits one key event per press over valid/ready.
//           Optional auto-repeat events enabled by macro KEY_SCAN_REPEAT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module key_scan_arbiter #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 9,
  parameter int REPEAT_CYCLES   = 16
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_KEYS-1:0]         keys_in,
  input  logic                        evt_ready,
  output logic                        evt_valid,
  output logic [$clog2(NUM_KEYS)-1:0] evt_key,
  output logic                        evt_repeat,
  output logic                        busy
);

  localparam int c_KEY_W = $clog2(NUM_KEYS);
  localparam int c_CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  if (NUM_KEYS < 2 || NUM_KEYS > 16 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("key_scan_arbiter: parameter out of range");
  end

`ifdef KEY_SCAN_REPEAT_EN
  localparam int c_RPT_W = $clog2(REPEAT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_SCAN     = 3'd0,
    S_HOLD     = 3'd1,
    S_REGISTER = 3'd2,
    S_EMIT     = 3'd3,
    S_EMIT_RPT = 3'd4
  } t_state;

  logic [c_RPT_W-1:0] r_rpt_cnt;
  logic               r_rel;
  logic               r_evt_repeat;
`else
  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_HOLD     = 2'd1,
    S_REGISTER = 2'd2,
    S_EMIT     = 2'd3
  } t_state;
`endif

  t_state             r_state;
  logic [c_KEY_W-1:0] r_rr_ptr;
  logic [c_KEY_W-1:0] r_grant;
  logic [c_CNT_W-1:0] r_count;
  logic               r_evt_valid;
  logic [c_KEY_W-1:0] r_evt_key;

  logic               w_any;
  logic [c_KEY_W-1:0] w_pick;
  logic [c_KEY_W-1:0] w_idx;
  logic [c_KEY_W-1:0] w_grant_next;
  logic               w_key_hi;

  // Walk offsets from highest to lowest so the lowest offset from rr_ptr wins.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_idx  = '0;
    for (int off = NUM_KEYS - 1; off >= 0; off--) begin
      w_idx = c_KEY_W'((int'(r_rr_ptr) + off) % NUM_KEYS);
      if (keys_in[w_idx]) begin
        w_any  = 1'b1;
        w_pick = w_idx;
      end
    end
  end

  assign w_grant_next = (r_grant == c_KEY_W'(NUM_KEYS - 1)) ? '0 : r_grant + c_KEY_W'(1);
  assign w_key_hi     = keys_in[r_grant];

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_SCAN;
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_count     <= '0;
      r_evt_valid <= 1'b0;
      r_evt_key   <= '0;
`ifdef KEY_SCAN_REPEAT_EN
      r_rpt_cnt    <= '0;
      r_rel        <= 1'b0;
      r_evt_repeat <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_SCAN: begin
          if (w_any) begin
            r_state <= S_HOLD;
            r_grant <= w_pick;
            r_count <= '0;
          end
        end

        S_HOLD: begin
          if (!w_key_hi) begin
            r_state  <= S_SCAN;
            r_rr_ptr <= w_grant_next;
          end else if (r_count == c_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_state <= S_REGISTER;
`ifdef KEY_SCAN_REPEAT_EN
            r_rpt_cnt <= '0;
`endif
          end else if (r_count < c_CNT_W'(DEBOUNCE_CYCLES)) begin
            r_count <= r_count + c_CNT_W'(1);
          end
        end

        S_REGISTER: begin
          if (!w_key_hi) begin
            r_state <= S_EMIT;
`ifdef KEY_SCAN_REPEAT_EN
          end else if (r_rpt_cnt == c_RPT_W'(REPEAT_CYCLES - 1)) begin
            r_state      <= S_EMIT_RPT;
            r_rpt_cnt    <= '0;
            r_rel        <= 1'b0;
            r_evt_valid  <= 1'b1;
            r_evt_key    <= r_grant;
            r_evt_repeat <= 1'b1;
          end else begin
            r_rpt_cnt <= r_rpt_cnt + c_RPT_W'(1);
`endif
          end
        end

        // Valid rises one cycle after entry, giving the release event its fixed latency.
        S_EMIT: begin
          if (!r_evt_valid) begin
            r_evt_valid <= 1'b1;
            r_evt_key   <= r_grant;
`ifdef KEY_SCAN_REPEAT_EN
            r_evt_repeat <= 1'b0;
`endif
          end else if (evt_ready) begin
            r_evt_valid <= 1'b0;
            r_state     <= S_SCAN;
            r_rr_ptr    <= w_grant_next;
          end
        end

`ifdef KEY_SCAN_REPEAT_EN
        // A release seen while the repeat event waits is remembered for the exit.
        S_EMIT_RPT: begin
          if (evt_ready) begin
            r_evt_valid  <= 1'b0;
            r_evt_repeat <= 1'b0;
            r_state      <= (r_rel || !w_key_hi) ? S_EMIT : S_REGISTER;
          end else if (!w_key_hi) begin
            r_rel <= 1'b1;
          end
        end
`endif

        default: r_state <= S_SCAN;
      endcase
    end
  end

  assign evt_valid = r_evt_valid;
  assign evt_key   = r_evt_key;
  assign busy      = (r_state != S_SCAN);
`ifdef KEY_SCAN_REPEAT_EN
  assign evt_repeat = r_evt_repeat;
`else
  assign evt_repeat = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_key_scan_arbiter.sv
// ============================================================================
// Module  : tb_key_scan_arbiter
// Brief   : Scoreboard bench for key_scan_arbiter (NUM_KEYS=4, DEBOUNCE=9).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_scan_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] keys_in;
  logic       evt_ready;
  logic       evt_valid;
  logic [1:0] evt_key;
  logic       evt_repeat;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];

  key_scan_arbiter #(
    .NUM_KEYS       (4),
    .DEBOUNCE_CYCLES(9),
    .REPEAT_CYCLES  (16)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .keys_in   (keys_in),
    .evt_ready (evt_ready),
    .evt_valid (evt_valid),
    .evt_key   (evt_key),
    .evt_repeat(evt_repeat),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int enc(input int key, input int rep);
    return key * 2 + rep;
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic drain(input string tag, input int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) tick;
    check(tag, exp_q.size(), 0);
    repeat (5) tick;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 30 && !evt_valid; i++) tick;
    check(tag, evt_valid, 1);
  endtask

  // Every transfer seen on the bus must match the head of the expected queue.
  always @(negedge CLK) begin
    if (!RST && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_evt", {evt_key, evt_repeat}, 32'hFF);
      end else begin
        check("evt_key_rep", {evt_key, evt_repeat}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RST       = 1'b1;
    keys_in   = '0;
    evt_ready = 1'b1;
    repeat (3) tick;
    check("rst_valid", evt_valid, 0);
    check("rst_key", evt_key, 0);
    check("rst_repeat", evt_repeat, 0);
    check("rst_busy", busy, 0);

    // Clean press of key 1 with release latency check
    RST = 1'b0;
    exp_q.push_back(enc(1, 0));
    keys_in[1] = 1'b1;
    repeat (20) tick;
    keys_in[1] = 1'b0;
    tick;
    check("t1_valid_early", evt_valid, 0);
    tick;
    check("t1_valid_rise", evt_valid, 1);
    check("t1_key", evt_key, 1);
    tick;
    check("t1_valid_fall", evt_valid, 0);
    check("t1_busy_after", busy, 0);
    drain("t1_drain", 10);

    // Glitch on key 2 rejected; rr_ptr then points at key 3
    keys_in[2] = 1'b1;
    repeat (5) tick;
    keys_in[2] = 1'b0;
    tick;
    tick;
    check("t2_busy", busy, 0);
    exp_q.push_back(enc(3, 0));
    keys_in = 4'b1100;
    repeat (12) tick;
    keys_in = '0;
    drain("t2_drain", 20);

    // Simultaneous keys 0 and 3 from reset
    RST = 1'b1;
    tick;
    RST = 1'b0;
    exp_q.push_back(enc(0, 0));
    exp_q.push_back(enc(3, 0));
    keys_in = 4'b1001;
    repeat (30) tick;
    keys_in[0] = 1'b0;
    repeat (30) tick;
    keys_in[3] = 1'b0;
    drain("t3_drain", 20);

    // Back-pressure while key 2 toggles, then key 2 held after transfer
    evt_ready = 1'b0;
    exp_q.push_back(enc(1, 0));
    exp_q.push_back(enc(2, 0));
    keys_in[1] = 1'b1;
    repeat (12) tick;
    keys_in[1] = 1'b0;
    wait_valid("t4_wait_valid");
    for (int i = 0; i < 10; i++) begin
      keys_in[2] = ~keys_in[2];
      tick;
      check("t4_hold_valid", evt_valid, 1);
      check("t4_hold_key", evt_key, 1);
    end
    keys_in[2] = 1'b1;
    evt_ready  = 1'b1;
    tick;
    check("t4_after_xfer", evt_valid, 0);
    repeat (14) tick;
    keys_in[2] = 1'b0;
    drain("t4_drain", 20);

    // Reset in HOLD and in EMIT
    keys_in[0] = 1'b1;
    repeat (3) tick;
    check("t5_busy_hold", busy, 1);
    RST     = 1'b1;
    keys_in = '0;
    tick;
    check("t5_hold_valid", evt_valid, 0);
    check("t5_hold_busy", busy, 0);
    RST       = 1'b0;
    evt_ready = 1'b0;
    keys_in[0] = 1'b1;
    repeat (12) tick;
    keys_in = '0;
    wait_valid("t5_wait_valid");
    RST = 1'b1;
    tick;
    check("t5_emit_valid", evt_valid, 0);
    check("t5_emit_key", evt_key, 0);
    check("t5_emit_busy", busy, 0);
    RST       = 1'b0;
    evt_ready = 1'b1;
    repeat (5) tick;
    exp_q.push_back(enc(3, 0));
    keys_in[3] = 1'b1;
    repeat (12) tick;
    keys_in = '0;
    drain("t5_drain", 20);

    // Long hold on key 1: repeat events only when the feature is built in
`ifdef KEY_SCAN_REPEAT_EN
    repeat (3) exp_q.push_back(enc(1, 1));
`endif
    exp_q.push_back(enc(1, 0));
    keys_in[1] = 1'b1;
    repeat (60) tick;
    keys_in[1] = 1'b0;
    drain("t6_drain", 30);

    repeat (10) tick;
    check("final_queue_empty", exp_q.size(), 0);
    check("final_busy", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
